// File: rtl/pos_cell_dbuf_if.sv
// Bus bundle for the double-buffered per-cell position memory.
// The read port, the append port and the bank-swap handshake are grouped here.
// The master side issues requests and the slave side (the memory) answers them.
interface pos_cell_dbuf_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_count;
   logic                  wr_overflow;

   logic                  swap_req;
   logic                  swap_done;
   logic                  rd_bank;

   modport master (
      output rd_en, rd_addr, wr_en, wr_data, swap_req,
      input  rd_ready, rd_data, rd_valid, wr_ready, wr_count, wr_overflow,
             swap_done, rd_bank
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_data, swap_req,
      output rd_ready, rd_data, rd_valid, wr_ready, wr_count, wr_overflow,
             swap_done, rd_bank
   );
endinterface

// File: rtl/pos_cell_dbuf.sv
// Double-buffered per-cell position memory.
// Force evaluation reads the current step from the read bank while motion
// update appends next-step positions into the other bank. A swap handshake
// exchanges the banks at the step boundary. Address 0 of the read bank
// returns that bank's particle count, which lives in registers and not in RAM.
module pos_cell_dbuf #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int INIT_COUNT   = 0
) (
   input logic           clock,
   input logic           rst,
   pos_cell_dbuf_if.slave bus
);

   localparam int IDX_WIDTH = (PARTICLE_NUM > 1) ? $clog2(PARTICLE_NUM) : 1;
   localparam logic [ADDR_WIDTH:0]   PTR_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   PTR_FULL = (ADDR_WIDTH+1)'(PARTICLE_NUM);
   localparam logic [ADDR_WIDTH-1:0] CNT_INIT = ADDR_WIDTH'(INIT_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SWAP
   } state_t;

   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_COUNT,
      SEL_RAM
   } rdsel_t;

   // Swap control and write-side bookkeeping
   state_t                r_state;
   logic                  r_rdBank;
   logic                  r_rdReady;
   logic                  r_wrReady;
   logic                  r_swapDone;
   logic                  r_wrOverflow;
   logic [ADDR_WIDTH:0]   r_wrPtr;
   logic [ADDR_WIDTH-1:0] r_wrCount;
   logic [ADDR_WIDTH-1:0] r_count [2];

   // Read pipeline: stage A lines up with the RAM read register,
   // stage B with the RAM output register, then the rd_data register.
   logic                  r_vA;
   logic                  r_vB;
   rdsel_t                r_selA;
   rdsel_t                r_selB;
   logic [ADDR_WIDTH-1:0] r_cntA;
   logic [ADDR_WIDTH-1:0] r_cntB;
   logic                  r_bankA;
   logic                  r_bankB;
   logic                  r_rdValid;
   logic [DATA_WIDTH-1:0] r_rdData;

   logic                  w_rdAccept;
   logic                  w_rdIsCount;
   logic                  w_rdInRam;
   rdsel_t                w_rdSel;
   logic [IDX_WIDTH-1:0]  w_rdIdx;
   logic                  w_wrAccept;
   logic                  w_wrFull;
   logic                  w_wrStore;
   logic [IDX_WIDTH-1:0]  w_wrIdx;
   logic [DATA_WIDTH-1:0] w_bankOut [2];

   assign w_rdAccept  = bus.rd_en && r_rdReady;
   assign w_rdIsCount = (bus.rd_addr == '0);
   assign w_rdInRam   = !w_rdIsCount && ({1'b0, bus.rd_addr} < PTR_FULL);
   assign w_rdSel     = w_rdIsCount ? SEL_COUNT : (w_rdInRam ? SEL_RAM : SEL_ZERO);
   assign w_rdIdx     = w_rdInRam ? bus.rd_addr[IDX_WIDTH-1:0] : '0;

   // A full bank still reports wr_ready; the append is simply dropped and flagged.
   assign w_wrAccept  = bus.wr_en && r_wrReady;
   assign w_wrFull    = (r_wrPtr == PTR_FULL);
   assign w_wrStore   = w_wrAccept && !w_wrFull;
   assign w_wrIdx     = w_wrFull ? '0 : r_wrPtr[IDX_WIDTH-1:0];

   // The two banks never share a port in the same cycle: the read bank only
   // sees read addresses and the write bank only sees the append pointer.
   for (genvar gb = 0; gb < 2; gb++) begin : g_bank
      logic [DATA_WIDTH-1:0] r_mem [PARTICLE_NUM];
      logic [DATA_WIDTH-1:0] r_memQ;
      logic [DATA_WIDTH-1:0] r_memOut;
      logic [IDX_WIDTH-1:0]  w_addr;
      logic                  w_we;

      assign w_addr = (r_rdBank == 1'(gb)) ? w_rdIdx : w_wrIdx;
      assign w_we   = w_wrStore && (r_rdBank != 1'(gb));

      // Single-port RAM with read register and output register; contents survive reset.
      always_ff @(posedge clock) begin
         if (w_we) begin
            r_mem[w_addr] <= bus.wr_data;
         end
         r_memQ   <= r_mem[w_addr];
         r_memOut <= r_memQ;
      end

      assign w_bankOut[gb] = r_memOut;
   end

   // Swap FSM plus append pointer, counts and sticky overflow, all registered.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rdBank     <= 1'b0;
         r_rdReady    <= 1'b1;
         r_wrReady    <= 1'b1;
         r_swapDone   <= 1'b0;
         r_wrOverflow <= 1'b0;
         r_wrPtr      <= PTR_ONE;
         r_wrCount    <= '0;
         r_count[0]   <= CNT_INIT;
         r_count[1]   <= '0;
      end else begin
         r_swapDone <= 1'b0;

         if (w_wrAccept) begin
            if (w_wrFull) begin
               r_wrOverflow <= 1'b1;
            end else begin
               r_wrPtr             <= r_wrPtr + PTR_ONE;
               r_wrCount           <= r_wrPtr[ADDR_WIDTH-1:0];
               r_count[~r_rdBank]  <= r_wrPtr[ADDR_WIDTH-1:0];
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (bus.swap_req) begin
                  r_state   <= ST_DRAIN;
                  r_rdReady <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!r_vA) begin
                  r_state   <= ST_SWAP;
                  r_wrReady <= 1'b0;
               end
            end
            ST_SWAP: begin
               r_count[~r_rdBank] <= r_wrCount;
               r_count[r_rdBank]  <= '0;
               r_rdBank           <= ~r_rdBank;
               r_wrPtr            <= PTR_ONE;
               r_wrCount          <= '0;
               r_wrOverflow       <= 1'b0;
               r_swapDone         <= 1'b1;
               r_rdReady          <= 1'b1;
               r_wrReady          <= 1'b1;
               r_state            <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read pipeline: carries request tags alongside the RAM and forces rd_data to zero when idle.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_vA      <= 1'b0;
         r_vB      <= 1'b0;
         r_selA    <= SEL_ZERO;
         r_selB    <= SEL_ZERO;
         r_cntA    <= '0;
         r_cntB    <= '0;
         r_bankA   <= 1'b0;
         r_bankB   <= 1'b0;
         r_rdValid <= 1'b0;
         r_rdData  <= '0;
      end else begin
         r_vA      <= w_rdAccept;
         r_selA    <= w_rdSel;
         r_cntA    <= r_count[r_rdBank];
         r_bankA   <= r_rdBank;

         r_vB      <= r_vA;
         r_selB    <= r_selA;
         r_cntB    <= r_cntA;
         r_bankB   <= r_bankA;

         r_rdValid <= r_vB;
         if (r_vB) begin
            case (r_selB)
               SEL_COUNT: r_rdData <= DATA_WIDTH'(r_cntB);
               SEL_RAM:   r_rdData <= w_bankOut[r_bankB];
               default:   r_rdData <= '0;
            endcase
         end else begin
            r_rdData <= '0;
         end
      end
   end

   assign bus.rd_ready    = r_rdReady;
   assign bus.rd_data     = r_rdData;
   assign bus.rd_valid    = r_rdValid;
   assign bus.wr_ready    = r_wrReady;
   assign bus.wr_count    = r_wrCount;
   assign bus.wr_overflow = r_wrOverflow;
   assign bus.swap_done   = r_swapDone;
   assign bus.rd_bank     = r_rdBank;

endmodule

// File: tb/tb_pos_cell_dbuf.sv
// Bench for pos_cell_dbuf: a transaction-level model of the two banks, the
// counts and the swap timing, compared against the DUT every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_pos_cell_dbuf;

   localparam int DW   = 96;
   localparam int AW   = 3;
   localparam int PN   = 4;
   localparam int INIT = 3;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
      bit            known;
   } rd_t;

   logic clock;
   logic rst;
   bit   live;
   int   nChecks;
   int   nPass;

   pos_cell_dbuf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   pos_cell_dbuf #(
      .DATA_WIDTH  (DW),
      .PARTICLE_NUM(PN),
      .ADDR_WIDTH  (AW),
      .INIT_COUNT  (INIT)
   ) dut (
      .clock(clock),
      .rst  (rst),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model state: bank contents, counts and pending swap deadline.
   logic [DW-1:0] mMem   [2][PN];
   bit            mKnown [2][PN];
   int            mCount [2];
   int            mRdBank;
   int            mWrNum;
   bit            mOverflow;
   bit            mPending;
   int            mDue;
   int            mLastRead;
   int            edgeNo;
   rd_t           rdQ[$];

   bit            eRdValid;
   logic [DW-1:0] eRdData;
   bit            eDataKnown;
   bit            eRdReady;
   bit            eWrReady;
   int            eWrCount;
   bit            eSwapDone;

   function automatic logic [DW-1:0] rep(input logic [31:0] v);
      return {v, v, v};
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      nChecks++;
      if (act !== expv) begin
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end else begin
         nPass++;
      end
   endtask

   task automatic modelReset();
      mCount[0] = INIT;
      mCount[1] = 0;
      mRdBank   = 0;
      mWrNum    = 0;
      mOverflow = 0;
      mPending  = 0;
      mDue      = 0;
      mLastRead = -100;
      edgeNo    = 0;
      rdQ.delete();
      eRdValid   = 0;
      eRdData    = '0;
      eDataKnown = 1;
      eRdReady   = 1;
      eWrReady   = 1;
      eWrCount   = 0;
      eSwapDone  = 0;
   endtask

   task automatic modelStep(input bit rdEn, input int rdAddr, input bit wrEn,
                            input logic [DW-1:0] wrData, input bit swapReq);
      bit  rdReadyPre;
      bit  wrReadyPre;
      rd_t r;
      edgeNo++;
      rdReadyPre = !mPending;
      wrReadyPre = !(mPending && edgeNo == mDue);

      if (rdEn && rdReadyPre) begin
         r.due = edgeNo + 2;
         if (rdAddr == 0) begin
            r.data  = DW'(mCount[mRdBank]);
            r.known = 1;
         end else if (rdAddr < PN) begin
            r.data  = mMem[mRdBank][rdAddr];
            r.known = mKnown[mRdBank][rdAddr];
         end else begin
            r.data  = '0;
            r.known = 1;
         end
         rdQ.push_back(r);
         mLastRead = edgeNo;
      end

      if (wrEn && wrReadyPre) begin
         if (mWrNum == PN - 1) begin
            mOverflow = 1;
         end else begin
            mWrNum++;
            mMem[1-mRdBank][mWrNum]   = wrData;
            mKnown[1-mRdBank][mWrNum] = 1;
         end
      end

      eSwapDone = 0;
      if (mPending && edgeNo == mDue) begin
         mCount[1-mRdBank] = mWrNum;
         mCount[mRdBank]   = 0;
         mRdBank           = 1 - mRdBank;
         mWrNum            = 0;
         mOverflow         = 0;
         mPending          = 0;
         eSwapDone         = 1;
      end else if (!mPending && swapReq) begin
         mPending = 1;
         mDue     = (mLastRead + 3 > edgeNo + 2) ? mLastRead + 3 : edgeNo + 2;
      end

      eRdReady = !mPending;
      eWrReady = !(mPending && edgeNo + 1 == mDue);
      eWrCount = mWrNum;
      if (rdQ.size() > 0 && rdQ[0].due == edgeNo) begin
         r          = rdQ.pop_front();
         eRdValid   = 1;
         eRdData    = r.data;
         eDataKnown = r.known;
      end else begin
         eRdValid   = 0;
         eRdData    = '0;
         eDataKnown = 1;
      end
   endtask

   task automatic applyStimulus(input bit rdEn, input int rdAddr, input bit wrEn,
                                input logic [DW-1:0] wrData, input bit swapReq);
      bus.rd_en    = rdEn;
      bus.rd_addr  = AW'(rdAddr);
      bus.wr_en    = wrEn;
      bus.wr_data  = wrData;
      bus.swap_req = swapReq;
      @(posedge clock);
      #1;
      modelStep(rdEn, rdAddr, wrEn, wrData, swapReq);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 0, '0, 0);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.rd_en    = 1'b0;
      bus.wr_en    = 1'b0;
      bus.swap_req = 1'b0;
      modelReset();
      @(posedge clock);
      #1;
      rst = 1'b0;
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clock) begin
      if (live && !rst) begin
         checkOutput("rd_valid", DW'(bus.rd_valid), DW'(eRdValid));
         if (eDataKnown) begin
            checkOutput("rd_data", bus.rd_data, eRdData);
         end
         checkOutput("rd_ready", DW'(bus.rd_ready), DW'(eRdReady));
         checkOutput("wr_ready", DW'(bus.wr_ready), DW'(eWrReady));
         checkOutput("wr_count", DW'(bus.wr_count), DW'(eWrCount));
         checkOutput("wr_overflow", DW'(bus.wr_overflow), DW'(mOverflow));
         checkOutput("swap_done", DW'(bus.swap_done), DW'(eSwapDone));
         checkOutput("rd_bank", DW'(bus.rd_bank), DW'(mRdBank));
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] expSeq [4];
      nChecks = 0;
      nPass   = 0;
      live    = 0;
      bus.rd_addr = '0;
      bus.wr_data = '0;
      for (int b = 0; b < 2; b++) begin
         for (int a = 0; a < PN; a++) begin
            mMem[b][a]   = '0;
            mKnown[b][a] = 0;
         end
      end
      doReset();
      live = 1;

      // Reset state
      checkOutput("lit_reset_rd_bank", DW'(bus.rd_bank), DW'(0));
      checkOutput("lit_reset_wr_count", DW'(bus.wr_count), DW'(0));
      checkOutput("lit_reset_rd_ready", DW'(bus.rd_ready), DW'(1));

      // Count of bank 0 after reset, then the preloaded words (values not tracked)
      applyStimulus(1, 0, 0, '0, 0);
      idleCycles(2);
      checkOutput("lit_init_count", bus.rd_data, DW'(3));
      for (int a = 1; a <= 3; a++) applyStimulus(1, a, 0, '0, 0);
      idleCycles(2);

      // Append three words into bank 1
      applyStimulus(0, 0, 1, rep(32'h1), 0);
      applyStimulus(0, 0, 1, rep(32'h2), 0);
      applyStimulus(0, 0, 1, rep(32'h3), 0);
      checkOutput("lit_append_count", DW'(bus.wr_count), DW'(3));

      // Swap with empty read pipeline: done two edges after the request
      applyStimulus(0, 0, 0, '0, 1);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_swap_not_early", DW'(bus.swap_done), DW'(0));
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_swap_done", DW'(bus.swap_done), DW'(1));
      checkOutput("lit_swap_bank", DW'(bus.rd_bank), DW'(1));

      // Back-to-back reads of the new read bank
      expSeq[0] = DW'(3);
      expSeq[1] = rep(32'h1);
      expSeq[2] = rep(32'h2);
      expSeq[3] = rep(32'h3);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i < 4, (i < 4) ? i : 0, 0, '0, 0);
         if (i >= 2) checkOutput("lit_bank1_word", bus.rd_data, expSeq[i-2]);
      end

      // Out-of-range read returns zero with rd_valid
      applyStimulus(1, PN, 0, '0, 0);
      idleCycles(2);
      checkOutput("lit_oob_valid", DW'(bus.rd_valid), DW'(1));
      checkOutput("lit_oob_data", bus.rd_data, '0);

      // Overflow: four appends into a 3-particle bank
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, rep(32'h10 + 32'(i)), 0);
      checkOutput("lit_ovf_count", DW'(bus.wr_count), DW'(3));
      checkOutput("lit_ovf_flag", DW'(bus.wr_overflow), DW'(1));
      applyStimulus(0, 0, 0, '0, 1);
      idleCycles(2);
      checkOutput("lit_ovf_cleared", DW'(bus.wr_overflow), DW'(0));
      applyStimulus(1, 0, 0, '0, 0);
      applyStimulus(1, 3, 0, '0, 0);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_ovf_newcount", bus.rd_data, DW'(3));
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_ovf_word3", bus.rd_data, rep(32'h12));
      idleCycles(1);

      // Swap with two reads in flight
      applyStimulus(1, 1, 0, '0, 0);
      applyStimulus(1, 2, 0, '0, 1);
      checkOutput("lit_drain_rd_ready", DW'(bus.rd_ready), DW'(0));
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_inflight_a", bus.rd_data, rep(32'h10));
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_inflight_b", bus.rd_data, rep(32'h11));
      checkOutput("lit_inflight_wait", DW'(bus.swap_done), DW'(0));
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("lit_inflight_done", DW'(bus.swap_done), DW'(1));
      checkOutput("lit_inflight_bank", DW'(bus.rd_bank), DW'(1));
      idleCycles(1);

      // Reset during DRAIN drops the swap
      applyStimulus(1, 0, 0, '0, 1);
      doReset();
      idleCycles(3);
      checkOutput("lit_rst_bank", DW'(bus.rd_bank), DW'(0));
      checkOutput("lit_rst_wr_count", DW'(bus.wr_count), DW'(0));
      checkOutput("lit_rst_rd_ready", DW'(bus.rd_ready), DW'(1));
      applyStimulus(1, 0, 0, '0, 0);
      idleCycles(2);
      checkOutput("lit_rst_count0", bus.rd_data, DW'(3));

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 7),
                          $urandom_range(0, 2) != 0, {$urandom, $urandom, $urandom},
                          $urandom_range(0, 9) == 0);
         end
      end
      idleCycles(4);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
